// File: rtl/wbm_uart_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge: command fields, status codes, states.
package wbm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_TX_STATUS,
    ST_TX_DATA
  } state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_RSV_MSB = 6;
  localparam int CMD_RSV_LSB = 4;
  localparam int CMD_ADR_MSB = 3;
  localparam int CMD_ADR_LSB = 0;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;

  // Clocks per UART bit, never below 1 so degenerate parameters still elaborate.
  function automatic int ticks_per_baud(input int clk_hz, input int baud_hz);
    int t;
    t = (baud_hz > 0) ? clk_hz / baud_hz : 0;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/wbm_uart_rxd.sv
// 8N1 UART receiver: start-bit recheck at half bit, mid-bit sampling, byte strobe / framing error.
module wbm_uart_rxd
  import wbm_uart_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int HALF = (TICKS / 2 < 1) ? 1 : TICKS / 2;
  localparam int CW   = (TICKS < 2) ? 1 : $clog2(TICKS);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      st_q    <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      st_q    <= st_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (!rx_s) begin
          st_d   = RX_START;
          tick_d = CW'(HALF - 1);
        end
      end
      RX_START: begin
        if (tick_q == '0) begin
          if (!rx_s) begin
            st_d   = RX_DATA;
            tick_d = CW'(TICKS - 1);
            bit_d  = '0;
          end else begin
            st_d = RX_IDLE;
          end
        end else begin
          tick_d = tick_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (tick_q == '0) begin
          sh_d   = {rx_s, sh_q[7:1]};
          tick_d = CW'(TICKS - 1);
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          tick_d = tick_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (tick_q == '0) begin
          if (rx_s) begin
            valid_d = 1'b1;
            st_d    = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
            st_d   = RX_BREAK;
          end
        end else begin
          tick_d = tick_q - CW'(1);
        end
      end
      // A low stop bit must not be mistaken for the next start bit.
      RX_BREAK: if (rx_s) st_d = RX_IDLE;
      default: st_d = RX_IDLE;
    endcase
  end

  assign data_o      = sh_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/wbm_uart.sv
// UART command bridge to a Wishbone B4 pipelined master: 1 command byte (+4 write bytes) in,
// status byte (+4 read bytes) out.
module wbm_uart
  import wbm_uart_pkg::*;
#(
  parameter int WB_CLK_HZ = 0,
  parameter int OUTPUT_HZ = 9600,
  parameter int TIMEOUT   = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int TICKS = ticks_per_baud(WB_CLK_HZ, OUTPUT_HZ);
  localparam int TW    = (TICKS < 2) ? 1 : $clog2(TICKS);
  localparam int TOW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       unused_ferr;

  wbm_uart_rxd #(.TICKS(TICKS)) u_rxd (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .rx_i       (uart_rx),
    .data_o     (rx_byte),
    .valid_o    (rx_valid),
    .frame_err_o(unused_ferr)
  );

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           cmd_we_q, cmd_we_d;
  logic [3:0]     cmd_adr_q, cmd_adr_d;
  logic           cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]     adr_q, adr_d;
  logic [31:0]    dat_q, dat_d, rdata_q, rdata_d;
  logic [TOW-1:0] to_q, to_d;
  logic           ok_q, ok_d;
  logic           go, fin_ok, fin_to;
  logic           tx_load, tx_done;
  logic [7:0]     tx_byte;

  logic           txbusy_q;
  logic [9:0]     txf_q;
  logic [3:0]     txb_q;
  logic [TW-1:0]  txt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_we_q  <= 1'b0;
      cmd_adr_q <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata_q   <= '0;
      to_q      <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_we_q  <= cmd_we_d;
      cmd_adr_q <= cmd_adr_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      to_q      <= to_d;
      ok_q      <= ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_we_d  = cmd_we_q;
    cmd_adr_d = cmd_adr_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;
    to_d      = to_q;
    ok_d      = ok_q;
    go        = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    tx_load   = 1'b0;
    tx_byte   = STATUS_OK;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte[CMD_RSV_MSB:CMD_RSV_LSB] == '0) begin
          cmd_we_d  = rx_byte[CMD_WE_BIT];
          cmd_adr_d = rx_byte[CMD_ADR_MSB:CMD_ADR_LSB];
          cnt_d     = '0;
          if (rx_byte[CMD_WE_BIT]) state_d = ST_RX_DATA;
          else                     go      = 1'b1;
        end
      end
      ST_RX_DATA: begin
        if (rx_valid) begin
          dat_d = {dat_q[23:0], rx_byte};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) go = 1'b1;
        end
      end
      ST_WB_REQ, ST_WB_WAIT: begin
        if (state_q == ST_WB_REQ && !wbm_stall_i) begin
          stb_d   = 1'b0;
          state_d = ST_WB_WAIT;
        end
        // An ack counts only once the strobe has been accepted.
        if ((state_q == ST_WB_WAIT || !wbm_stall_i) && wbm_ack_i) fin_ok = 1'b1;
        else if (to_q == '0)                                     fin_to = 1'b1;
        else                                                     to_d   = to_q - TOW'(1);
      end
      ST_TX_STATUS: begin
        if (tx_done) begin
          if (ok_q && !cmd_we_q) begin
            tx_load = 1'b1;
            tx_byte = rdata_q[31:24];
            rdata_d = {rdata_q[23:0], 8'h00};
            cnt_d   = 2'd3;
            state_d = ST_TX_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TX_DATA: begin
        if (tx_done) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            tx_load = 1'b1;
            tx_byte = rdata_q[31:24];
            rdata_d = {rdata_q[23:0], 8'h00};
            cnt_d   = cnt_q - 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go) begin
      state_d = ST_WB_REQ;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = cmd_we_d;
      adr_d   = cmd_adr_d;
      to_d    = TOW'(TIMEOUT - 1);
    end
    if (fin_ok || fin_to) begin
      state_d = ST_TX_STATUS;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      ok_d    = fin_ok;
      if (fin_ok && !cmd_we_q) rdata_d = wbm_dat_i;
      tx_load = 1'b1;
      tx_byte = fin_ok ? STATUS_OK : STATUS_TIMEOUT;
    end
  end

  // Reloading on the last stop-bit clock keeps reply bytes back-to-back.
  assign tx_done = txbusy_q && txt_q == '0 && txb_q == '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      txbusy_q <= 1'b0;
      txf_q    <= '1;
      txb_q    <= '0;
      txt_q    <= '0;
    end else if (tx_load) begin
      txbusy_q <= 1'b1;
      txf_q    <= {1'b1, tx_byte, 1'b0};
      txb_q    <= 4'd9;
      txt_q    <= TW'(TICKS - 1);
    end else if (txbusy_q) begin
      if (txt_q == '0) begin
        if (txb_q == '0) begin
          txbusy_q <= 1'b0;
        end else begin
          txf_q <= {1'b1, txf_q[9:1]};
          txb_q <= txb_q - 4'd1;
          txt_q <= TW'(TICKS - 1);
        end
      end else begin
        txt_q <= txt_q - TW'(1);
      end
    end
  end

  assign uart_tx   = txbusy_q ? txf_q[0] : 1'b1;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wbm_uart.sv
// Scoreboard bench for wbm_uart at 4 clocks per bit with a configurable pipelined slave.
module tb_wbm_uart;

  localparam int TICKS = 4;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack, stall, rx, tx;
  logic [3:0]  adr;
  logic [31:0] dat_o, dat_i;

  always #5 clk = ~clk;

  wbm_uart #(.WB_CLK_HZ(38400), .OUTPUT_HZ(9600), .TIMEOUT(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat_o),
    .wbm_dat_i  (dat_i),
    .wbm_ack_i  (ack),
    .wbm_stall_i(stall),
    .uart_rx    (rx),
    .uart_tx    (tx)
  );

  typedef struct {
    logic [3:0]  adr;
    logic        we;
    logic [31:0] dat;
    bit          chk_dat;
    int          stb_len;
    int          cyc_len;
  } bus_t;

  typedef struct {
    logic [7:0] b;
    bit         chained;
  } txe_t;

  bus_t exp_bus[$];
  txe_t exp_tx[$];
  int   n_vec = 0, n_err = 0;
  int   n_bus_seen = 0, n_tx_seen = 0, ncyc = 0;
  bit   bus_ignore = 1'b0;
  int   sl_stall = 0, sl_ack_dly = 0;
  bit   sl_noack = 1'b0;
  logic [31:0] sl_rdata = 32'h0;

  // Slave model and bus monitor: drives stall/ack for the coming edge, scores each finished cycle.
  initial begin : bus_mon
    int age, since;
    bit acc, in_txn;
    logic [3:0] c_adr;
    logic c_we;
    logic [31:0] c_dat;
    int c_stb, c_cyc;
    bus_t e;
    ack = 1'b0; stall = 1'b0; dat_i = 32'h0;
    in_txn = 1'b0; acc = 1'b0; age = 0; since = 0;
    c_adr = '0; c_we = 1'b0; c_dat = '0; c_stb = 0; c_cyc = 0;
    forever begin
      @(negedge clk);
      ack = 1'b0; stall = 1'b0;
      if (cyc === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1'b1; acc = 1'b0; age = 0; since = 0; c_stb = 0; c_cyc = 0;
        end
        c_cyc++;
        if (stb === 1'b1) c_stb++;
        if (stb === 1'b1 && !acc) begin
          stall = (age < sl_stall);
          age++;
          if (!stall) begin
            acc = 1'b1; c_adr = adr; c_we = we; c_dat = dat_o;
            ack = !sl_noack && sl_ack_dly == 0;
          end
        end else if (acc) begin
          since++;
          ack = !sl_noack && since == sl_ack_dly;
        end
      end else if (in_txn) begin
        in_txn = 1'b0;
        if (bus_ignore) begin
          bus_ignore = 1'b0;
        end else begin
          n_bus_seen++;
          n_vec++;
          if (exp_bus.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: adr=%0h we=%0b dat=%08h, wanted no cycle", c_adr, c_we, c_dat);
          end else begin
            e = exp_bus.pop_front();
            if (c_adr !== e.adr || c_we !== e.we || (e.chk_dat && c_dat !== e.dat)) begin
              n_err++;
              $display("FAIL bus_req: got adr=%0h we=%0b dat=%08h, wanted adr=%0h we=%0b dat=%08h",
                       c_adr, c_we, c_dat, e.adr, e.we, e.dat);
            end
            n_vec++;
            if (c_stb != e.stb_len) begin
              n_err++;
              $display("FAIL bus_stb_len: got %0d cycles, wanted %0d", c_stb, e.stb_len);
            end
            n_vec++;
            if (c_cyc != e.cyc_len) begin
              n_err++;
              $display("FAIL bus_cyc_len: got %0d cycles, wanted %0d", c_cyc, e.cyc_len);
            end
          end
        end
      end
      dat_i = ack ? sl_rdata : 32'h0;
    end
  end

  // Serial reply monitor: mid-bit sampling, byte and spacing checks against the expected queue.
  initial begin : tx_mon
    int off, k, cur_start, prev_start;
    bit busy;
    logic [7:0] sh;
    txe_t e;
    busy = 1'b0; off = 0; k = 0; cur_start = 0; prev_start = 0; sh = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!busy && tx === 1'b0) begin
        busy = 1'b1; off = 0; cur_start = ncyc;
      end
      if (busy) begin
        if (off % TICKS == TICKS / 2) begin
          k = off / TICKS;
          if (k == 0 && tx !== 1'b0) begin
            busy = 1'b0;
          end else if (k >= 1 && k <= 8) begin
            sh[k-1] = tx;
          end else if (k == 9) begin
            busy = 1'b0;
            n_tx_seen++;
            n_vec++;
            if (tx !== 1'b1) begin
              n_err++;
              $display("FAIL tx_stop: got %b, wanted 1", tx);
            end
            n_vec++;
            if (exp_tx.size() == 0) begin
              n_err++;
              $display("FAIL tx_unexpected: got %02h, wanted no byte", sh);
            end else begin
              e = exp_tx.pop_front();
              if (sh !== e.b) begin
                n_err++;
                $display("FAIL tx_byte: got %02h, wanted %02h", sh, e.b);
              end
              if (e.chained) begin
                n_vec++;
                if (cur_start - prev_start != 10 * TICKS) begin
                  n_err++;
                  $display("FAIL tx_gap: start spacing %0d clocks, wanted %0d", cur_start - prev_start, 10 * TICKS);
                end
              end
            end
            prev_start = cur_start;
          end
        end
        off++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (TICKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (TICKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (TICKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (cyc !== 1'b0)    begin n_err++; $display("FAIL reset_cyc: got %b, wanted 0", cyc); end
    n_vec++; if (stb !== 1'b0)    begin n_err++; $display("FAIL reset_stb: got %b, wanted 0", stb); end
    n_vec++; if (we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %b, wanted 0", we); end
    n_vec++; if (adr !== 4'h0)    begin n_err++; $display("FAIL reset_adr: got %h, wanted 0", adr); end
    n_vec++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat: got %08h, wanted 0", dat_o); end
    n_vec++; if (tx !== 1'b1)     begin n_err++; $display("FAIL reset_tx: got %b, wanted 1", tx); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    int nb;
    nb = n_bus_seen;
    sl_stall = 0; sl_ack_dly = 0; sl_noack = 1'b0;
    exp_bus.push_back('{adr: 4'h3, we: 1'b1, dat: 32'hDEADBEEF, chk_dat: 1'b1, stb_len: 1, cyc_len: 1});
    exp_tx.push_back('{b: 8'h00, chained: 1'b0});
    send_byte(8'h83, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    for (int i = 0; i < 2000 && (exp_tx.size() > 0 || exp_bus.size() > 0); i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n_vec++;
    if (exp_tx.size() != 0 || exp_bus.size() != 0 || n_bus_seen - nb != 1) begin
      n_err++;
      $display("FAIL write_done: %0d tx / %0d bus pending, %0d cycles seen, wanted 0/0/1",
               exp_tx.size(), exp_bus.size(), n_bus_seen - nb);
      exp_tx.delete(); exp_bus.delete();
    end
  endtask

  task automatic test_read_stall;
    int nt;
    nt = n_tx_seen;
    sl_stall = 3; sl_ack_dly = 2; sl_noack = 1'b0; sl_rdata = 32'h12345678;
    exp_bus.push_back('{adr: 4'h5, we: 1'b0, dat: 32'h0, chk_dat: 1'b0, stb_len: 4, cyc_len: 6});
    exp_tx.push_back('{b: 8'h00, chained: 1'b0});
    exp_tx.push_back('{b: 8'h12, chained: 1'b1});
    exp_tx.push_back('{b: 8'h34, chained: 1'b1});
    exp_tx.push_back('{b: 8'h56, chained: 1'b1});
    exp_tx.push_back('{b: 8'h78, chained: 1'b1});
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < 2000 && (exp_tx.size() > 0 || exp_bus.size() > 0); i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n_vec++;
    if (exp_tx.size() != 0 || exp_bus.size() != 0 || n_tx_seen - nt != 5) begin
      n_err++;
      $display("FAIL read_done: %0d tx / %0d bus pending, %0d bytes seen, wanted 0/0/5",
               exp_tx.size(), exp_bus.size(), n_tx_seen - nt);
      exp_tx.delete(); exp_bus.delete();
    end
  endtask

  task automatic test_timeout;
    int nt;
    nt = n_tx_seen;
    sl_stall = 0; sl_ack_dly = 0; sl_noack = 1'b1;
    exp_bus.push_back('{adr: 4'h1, we: 1'b0, dat: 32'h0, chk_dat: 1'b0, stb_len: 1, cyc_len: 16});
    exp_tx.push_back('{b: 8'hFF, chained: 1'b0});
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 2000 && (exp_tx.size() > 0 || exp_bus.size() > 0); i++) @(negedge clk);
    repeat (80) @(negedge clk);
    n_vec++;
    if (exp_tx.size() != 0 || exp_bus.size() != 0 || n_tx_seen - nt != 1) begin
      n_err++;
      $display("FAIL timeout_done: %0d tx / %0d bus pending, %0d bytes seen, wanted 0/0/1",
               exp_tx.size(), exp_bus.size(), n_tx_seen - nt);
      exp_tx.delete(); exp_bus.delete();
    end
    sl_noack = 1'b0;
  endtask

  task automatic test_rejects;
    int nb, nt;
    nb = n_bus_seen; nt = n_tx_seen;
    sl_stall = 0; sl_ack_dly = 1; sl_noack = 1'b0; sl_rdata = 32'hCAFEF00D;
    send_byte(8'h06, 1'b0);
    repeat (3 * TICKS) @(negedge clk);
    send_byte(8'h40, 1'b1);
    repeat (300) @(negedge clk);
    n_vec++;
    if (n_bus_seen != nb) begin
      n_err++; $display("FAIL reject_bus: got %0d cycles, wanted 0", n_bus_seen - nb);
    end
    n_vec++;
    if (n_tx_seen != nt) begin
      n_err++; $display("FAIL reject_tx: got %0d bytes, wanted 0", n_tx_seen - nt);
    end
    exp_bus.push_back('{adr: 4'h7, we: 1'b0, dat: 32'h0, chk_dat: 1'b0, stb_len: 1, cyc_len: 2});
    exp_tx.push_back('{b: 8'h00, chained: 1'b0});
    exp_tx.push_back('{b: 8'hCA, chained: 1'b1});
    exp_tx.push_back('{b: 8'hFE, chained: 1'b1});
    exp_tx.push_back('{b: 8'hF0, chained: 1'b1});
    exp_tx.push_back('{b: 8'h0D, chained: 1'b1});
    send_byte(8'h07, 1'b1);
    for (int i = 0; i < 2000 && (exp_tx.size() > 0 || exp_bus.size() > 0); i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n_vec++;
    if (exp_tx.size() != 0 || exp_bus.size() != 0) begin
      n_err++;
      $display("FAIL reject_then_read: %0d tx / %0d bus pending, wanted 0/0", exp_tx.size(), exp_bus.size());
      exp_tx.delete(); exp_bus.delete();
    end
  endtask

  task automatic test_reset_mid;
    int nt, waited;
    nt = n_tx_seen;
    sl_stall = 0; sl_ack_dly = 0; sl_noack = 1'b1;
    bus_ignore = 1'b1;
    send_byte(8'h02, 1'b1);
    waited = 0;
    while (!(cyc === 1'b1 && stb === 1'b0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= 500) begin
      n_err++; $display("FAIL rstmid_reach_wait: got no WB_WAIT within %0d clocks, wanted it", waited);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (cyc !== 1'b0) begin n_err++; $display("FAIL rstmid_cyc: got %b, wanted 0", cyc); end
    n_vec++; if (stb !== 1'b0) begin n_err++; $display("FAIL rstmid_stb: got %b, wanted 0", stb); end
    n_vec++; if (tx !== 1'b1)  begin n_err++; $display("FAIL rstmid_tx: got %b, wanted 1", tx); end
    rst = 1'b0;
    sl_noack = 1'b0;
    repeat (200) @(negedge clk);
    n_vec++;
    if (n_tx_seen != nt) begin
      n_err++; $display("FAIL rstmid_no_reply: got %0d bytes, wanted 0", n_tx_seen - nt);
    end
    bus_ignore = 1'b0;
    exp_bus.push_back('{adr: 4'hA, we: 1'b1, dat: 32'h01020304, chk_dat: 1'b1, stb_len: 1, cyc_len: 1});
    exp_tx.push_back('{b: 8'h00, chained: 1'b0});
    send_byte(8'h8A, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 2000 && (exp_tx.size() > 0 || exp_bus.size() > 0); i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n_vec++;
    if (exp_tx.size() != 0 || exp_bus.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_next_cmd: %0d tx / %0d bus pending, wanted 0/0", exp_tx.size(), exp_bus.size());
      exp_tx.delete(); exp_bus.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_write();
    test_read_stall();
    test_timeout();
    test_rejects();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
